// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage RISC-V core: widths, ALU op classes and
// the squashed-slot control encoding used by every pipeline register.
package cpu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;

    typedef enum logic [1:0] {
        AluOpAdd    = 2'b00,
        AluOpBranch = 2'b01,
        AluOpFunct  = 2'b10,
        AluOpImm    = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic [1:0] alu_op;
    } ctrl_t;

    // RegWrite=0 and no memory access: a squashed slot has no architectural effect.
    localparam ctrl_t CTRL_SQUASH = '0;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at its maximum value instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != '1)) begin
            cnt_o <= cnt_o + 1'b1;
        end
    end

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with hold, flush and load-use bubble handling,
// plus saturating counts of inserted bubbles and flushes.
module id_ex_pipe
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = cpu_pkg::DATA_W,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              bubble_i,
    input  logic              flush_i,
    input  logic              hold_i,
    input  logic              RegWrite_i,
    input  logic              MemToReg_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic              ALUSrc_i,
    input  logic [1:0]        ALUOp_i,
    input  logic [REG_W-1:0]  Rd_addr_i,
    input  logic [REG_W-1:0]  RS1addr_i,
    input  logic [REG_W-1:0]  RS2addr_i,
    input  logic [DATA_W-1:0] RS1data_i,
    input  logic [DATA_W-1:0] RS2data_i,
    input  logic [DATA_W-1:0] Imm_i,
    input  logic [9:0]        Funct_i,
    output logic              RegWrite_o,
    output logic              MemToReg_o,
    output logic              MemRead_o,
    output logic              MemWrite_o,
    output logic              ALUSrc_o,
    output logic [1:0]        ALUOp_o,
    output logic [REG_W-1:0]  Rd_addr_o,
    output logic [REG_W-1:0]  RS1addr_o,
    output logic [REG_W-1:0]  RS2addr_o,
    output logic [DATA_W-1:0] RS1data_o,
    output logic [DATA_W-1:0] RS2data_o,
    output logic [DATA_W-1:0] Imm_o,
    output logic [9:0]        Funct_o,
    output logic              valid_o,
    output logic [CNT_W-1:0]  bubble_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    ctrl_t ctrl_in;
    ctrl_t ctrl_q;
    logic  flush_inc;
    logic  bubble_inc;

    assign ctrl_in = '{reg_write: RegWrite_i, mem_to_reg: MemToReg_i, mem_read: MemRead_i,
                       mem_write: MemWrite_i, alu_src: ALUSrc_i, alu_op: ALUOp_i};

    // Flush wins over bubble; hold freezes both counts.
    assign flush_inc  = !hold_i && flush_i;
    assign bubble_inc = !hold_i && !flush_i && bubble_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_q    <= CTRL_SQUASH;
            Rd_addr_o <= '0;
            RS1addr_o <= '0;
            RS2addr_o <= '0;
            RS1data_o <= '0;
            RS2data_o <= '0;
            Imm_o     <= '0;
            Funct_o   <= '0;
            valid_o   <= 1'b0;
        end else if (!hold_i) begin
            if (flush_i || bubble_i) begin
                ctrl_q    <= CTRL_SQUASH;
                Rd_addr_o <= '0;
                RS1addr_o <= '0;
                RS2addr_o <= '0;
                RS1data_o <= '0;
                RS2data_o <= '0;
                Imm_o     <= '0;
                Funct_o   <= '0;
                valid_o   <= 1'b0;
            end else begin
                ctrl_q    <= ctrl_in;
                Rd_addr_o <= Rd_addr_i;
                RS1addr_o <= RS1addr_i;
                RS2addr_o <= RS2addr_i;
                RS1data_o <= RS1data_i;
                RS2data_o <= RS2data_i;
                Imm_o     <= Imm_i;
                Funct_o   <= Funct_i;
                valid_o   <= 1'b1;
            end
        end
    end

    assign RegWrite_o = ctrl_q.reg_write;
    assign MemToReg_o = ctrl_q.mem_to_reg;
    assign MemRead_o  = ctrl_q.mem_read;
    assign MemWrite_o = ctrl_q.mem_write;
    assign ALUSrc_o   = ctrl_q.alu_src;
    assign ALUOp_o    = ctrl_q.alu_op;

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_bubble_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (bubble_inc),
        .cnt_o (bubble_cnt_o)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (flush_inc),
        .cnt_o (flush_cnt_o)
    );

endmodule

// File: doc/id_ex_pipe.md
# id_ex_pipe

ID/EX pipeline register for the 5-stage RISC-V core. It sits directly downstream of the ID-stage control multiplexer. It captures the gated control bits, the destination register, and the operand/immediate datapath fields, and presents them to EX one cycle later. It also handles the three pipeline events at this boundary (load-use bubble, branch flush, downstream hold) and keeps saturating counts of inserted bubbles and flushes for performance debug.

## Interface
Parameters:
- DATA_W, 32, operand/immediate width
- CNT_W, 16, width of each event counter

Ports:
- clk_i  in  1  core clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- bubble_i  in  1  load-use stall from the hazard unit; same signal that zeroes the control mux this cycle
- flush_i  in  1  branch taken in ID; the incoming slot is squashed
- hold_i  in  1  downstream stall; EX must keep its current instruction
- RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i, ALUSrc_i  in  1 each  control bits from the control mux
- ALUOp_i  in  2  ALU op class
- Rd_addr_i, RS1addr_i, RS2addr_i  in  5 each  destination and source register indices (sources are used for forwarding)
- RS1data_i, RS2data_i, Imm_i  in  DATA_W each  operands and sign-extended immediate
- Funct_i  in  10  {funct7, funct3}
- Each of the above, with the _o suffix  out  same width  registered copy presented to EX
- valid_o  out  1  EX slot holds a real instruction
- bubble_cnt_o  out  CNT_W  bubbles inserted
- flush_cnt_o  out  CNT_W  flush squashes inserted

## Operation
- Priority on each rising edge: rst_i > hold_i > flush_i > bubble_i > normal load.
- **Reset:** every output goes to 0, including both counters and valid_o.
- **Hold:** all pipeline outputs keep their value. Counters do not change. flush_i and bubble_i are ignored. The hazard unit keeps asserting flush until hold drops.
- **Flush** (no hold):
  - Load a squashed slot: all control outputs, Rd/RS1/RS2 addresses, data fields and Funct go to 0, and valid_o goes to 0.
  - flush_cnt increments.
- **Bubble** (no hold, no flush):
  - Load a squashed slot, identical to flush, regardless of what appears on the control inputs.
  - bubble_cnt increments.
- **Normal:** every _o takes its _i value and valid_o goes to 1.
- Counters saturate at 2^CNT_W−1 and never wrap.
- Flush and bubble in the same cycle count as a flush only.
- Squashed slot encoding: RegWrite=0 and Rd=0, so forwarding and writeback never match. MemRead=0 and MemWrite=0, so there are no memory side effects.

## Timing
- Latency is 1 cycle from the input to the matching output.
- There is no combinational path from input to output; every output is a flop.
- When hold deasserts, the next edge loads normally. No data is lost, because the upstream stages stall on the same hold_i.
- Reset asserted mid-hold or mid-flush clears the block on that edge. The first post-reset load happens on the first edge with rst_i=0.
- Counter outputs update on the same edge as the squash they record.

## Structure
- **Shared package** `cpu_pkg`:
  - DATA_W
  - register-index width (5)
  - ALUOp encodings
  - the squashed-slot constant, reused by the control mux and the other pipeline registers
- **Sub-module** `sat_counter` (parameter WIDTH; ports clk_i, rst_i, inc_i, cnt_o), instantiated twice.
- The remainder is one sequential process.

## Test plan
- Reset: drive rst_i=1 with all inputs nonzero → after the edge, every output is 0 and both counters are 0.
- Normal load: RegWrite=1, Rd=5'd7, RS1data=32'h1234_5678, Imm=32'hFFFF_FFF0 → these values appear one edge later, with valid_o=1.
- Bubble: bubble_i=1 with RegWrite_i=1 and Rd_addr_i=9 → next cycle RegWrite_o=0, Rd_addr_o=0, valid_o=0, bubble_cnt_o=1.
- Hold beats flush: load Rd=3, then hold_i=1 and flush_i=1 for 3 cycles → Rd_addr_o stays 3, valid_o stays 1, flush_cnt_o stays 0. Drop hold while flush_i is still 1 → slot squashed and flush_cnt_o=1.
- Simultaneous flush and bubble → squashed slot, flush_cnt_o+1, bubble_cnt_o unchanged.
- Saturation: with CNT_W=4, apply 20 consecutive bubbles → bubble_cnt_o stops at 4'hF.
